// File: rtl/dm_sram_ctrl.sv
// CPU data-memory bus responder for a 256K x 16 asynchronous SRAM with active-low strobes.
// Define SRAM_BYTE_EN to add the dm_sel byte-lane port; otherwise every access is a full word.
`default_nettype none

module dm_sram_ctrl #(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [1:0]  BANK        = 2'b00
) (
    input  logic        clk_cpu,
    input  logic        rst,
    input  logic [15:0] dm_adr,
    input  logic [15:0] dm_dat_o,
    input  logic        dm_we,
    input  logic        dm_req,
`ifdef SRAM_BYTE_EN
    input  logic [1:0]  dm_sel,
`endif
    output logic [15:0] dm_dat_i,
    output logic        dm_ack,
    output logic [17:0] sram_a,
    output logic        sram_ce,
    output logic        sram_we,
    output logic        sram_oe,
    output logic        sram_lb,
    output logic        sram_ub,
    output logic [15:0] sram_d_o,
    output logic        sram_d_oe,
    input  logic [15:0] sram_d_i
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RECOV,
        ST_ACK
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  wait_cnt_reg, wait_cnt_next;
    logic        is_write_reg, is_write_next;
    logic        capture;
    logic        read_done;

    logic        ce_n_reg, ce_n_next;
    logic        we_n_reg, we_n_next;
    logic        oe_n_reg, oe_n_next;
    logic        d_oe_reg, d_oe_next;
    logic        ack_reg, ack_next;
    logic [1:0]  lane_n_reg, lane_n_next;
    logic [1:0]  lanes_next;
    logic        active_next;
    logic [17:0] adr_reg;
    logic [15:0] dout_reg;
    logic [15:0] rdata_reg;

    always_ff @(posedge clk_cpu or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= 4'd0;
            is_write_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            is_write_reg <= is_write_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        is_write_next = is_write_reg;
        capture       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (dm_req) begin
                    state_next    = ST_SETUP;
                    is_write_next = dm_we;
                    capture       = 1'b1;
                end
            end
            ST_SETUP: begin
                state_next    = ST_ACCESS;
                wait_cnt_next = WAIT_LOAD;
            end
            ST_ACCESS: begin
                if (wait_cnt_reg == 4'd0) begin
                    state_next = is_write_reg ? ST_RECOV : ST_ACK;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            ST_RECOV: state_next = ST_ACK;
            ST_ACK:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign read_done = (state_reg == ST_ACCESS) && (wait_cnt_reg == 4'd0) && !is_write_reg;

`ifdef SRAM_BYTE_EN
    logic [1:0] sel_reg;

    always_ff @(posedge clk_cpu or posedge rst) begin
        if (rst) begin
            sel_reg <= 2'b11;
        end else if (capture) begin
            sel_reg <= dm_sel;
        end
    end

    assign lanes_next = capture ? dm_sel : sel_reg;
`else
    assign lanes_next = 2'b11;
`endif

    // Strobes are computed from the upcoming state so every pin comes straight from a flop.
    always_comb begin
        active_next = (state_next == ST_SETUP) || (state_next == ST_ACCESS) ||
                      (state_next == ST_RECOV);
        ce_n_next   = !active_next;
        oe_n_next   = !(active_next && !is_write_next);
        we_n_next   = !((state_next == ST_ACCESS) && is_write_next);
        d_oe_next   = active_next && is_write_next;
        ack_next    = (state_next == ST_ACK);
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        assign lane_n_next[gi] = !(active_next && lanes_next[gi]);
    end

    always_ff @(posedge clk_cpu or posedge rst) begin
        if (rst) begin
            ce_n_reg   <= 1'b1;
            we_n_reg   <= 1'b1;
            oe_n_reg   <= 1'b1;
            d_oe_reg   <= 1'b0;
            ack_reg    <= 1'b0;
            lane_n_reg <= 2'b11;
            adr_reg    <= 18'd0;
            dout_reg   <= 16'd0;
            rdata_reg  <= 16'd0;
        end else begin
            ce_n_reg   <= ce_n_next;
            we_n_reg   <= we_n_next;
            oe_n_reg   <= oe_n_next;
            d_oe_reg   <= d_oe_next;
            ack_reg    <= ack_next;
            lane_n_reg <= lane_n_next;
            if (capture) begin
                adr_reg <= {BANK, dm_adr};
            end
            if (capture && dm_we) begin
                dout_reg <= dm_dat_o;
            end
            // Pins were already sampled by the I/O cell, so the last ACCESS edge sees settled data.
            if (read_done) begin
                rdata_reg <= sram_d_i;
            end
        end
    end

    assign dm_dat_i  = rdata_reg;
    assign dm_ack    = ack_reg;
    assign sram_a    = adr_reg;
    assign sram_ce   = ce_n_reg;
    assign sram_we   = we_n_reg;
    assign sram_oe   = oe_n_reg;
    assign sram_lb   = lane_n_reg[0];
    assign sram_ub   = lane_n_reg[1];
    assign sram_d_o  = dout_reg;
    assign sram_d_oe = d_oe_reg;

endmodule

`default_nettype wire

// File: tb/tb_dm_sram_ctrl.sv
// Self-checking bench for dm_sram_ctrl: three instances (WAIT_STATES 1, 0, 3) on pin-level SRAM models.
`timescale 1ns/1ps

module tb_dm_sram_ctrl;
    localparam int NU = 3;

    logic clk_cpu = 1'b0;
    logic rst = 1'b1;
    logic [NU-1:0][15:0] dm_adr, dm_dat_o, dm_dat_i, sram_d_o;
    logic [NU-1:0]       dm_we, dm_req, dm_ack;
    logic [NU-1:0][17:0] sram_a;
    logic [NU-1:0]       sram_ce, sram_we, sram_oe, sram_lb, sram_ub, sram_d_oe;
`ifdef SRAM_BYTE_EN
    logic [NU-1:0][1:0]  dm_sel;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int ack_cnt [NU] = '{default: 0};
    int we_low  [NU] = '{default: 0};
    int ub_low  [NU] = '{default: 0};
    int viol_oe = 0;
    int viol_we = 0;

    always #5 clk_cpu = ~clk_cpu;

    function automatic int ws_of(input int u);
        return (u == 0) ? 1 : ((u == 1) ? 0 : 3);
    endfunction

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    for (genvar gi = 0; gi < NU; gi++) begin : g_unit
        logic [15:0] d_i_q = 16'h0000;
        logic [15:0] mem [int];

        dm_sram_ctrl #(.WAIT_STATES(ws_of(gi)), .BANK(2'b00)) dut (
            .clk_cpu  (clk_cpu),
            .rst      (rst),
            .dm_adr   (dm_adr[gi]),
            .dm_dat_o (dm_dat_o[gi]),
            .dm_we    (dm_we[gi]),
            .dm_req   (dm_req[gi]),
`ifdef SRAM_BYTE_EN
            .dm_sel   (dm_sel[gi]),
`endif
            .dm_dat_i (dm_dat_i[gi]),
            .dm_ack   (dm_ack[gi]),
            .sram_a   (sram_a[gi]),
            .sram_ce  (sram_ce[gi]),
            .sram_we  (sram_we[gi]),
            .sram_oe  (sram_oe[gi]),
            .sram_lb  (sram_lb[gi]),
            .sram_ub  (sram_ub[gi]),
            .sram_d_o (sram_d_o[gi]),
            .sram_d_oe(sram_d_oe[gi]),
            .sram_d_i (d_i_q)
        );

        // Pin-level SRAM with the data input registered as by the I/O cell.
        always @(posedge clk_cpu) begin : pin_model
            logic [15:0] cur;
            int key;
            key = int'(sram_a[gi]);
            cur = mem.exists(key) ? mem[key] : init_val(sram_a[gi][15:0]);
            if (!sram_ce[gi] && !sram_we[gi] && sram_d_oe[gi]) begin
                if (!sram_lb[gi]) cur[7:0]  = sram_d_o[gi][7:0];
                if (!sram_ub[gi]) cur[15:8] = sram_d_o[gi][15:8];
                mem[key] = cur;
            end
            d_i_q <= (!sram_ce[gi] && !sram_oe[gi]) ? cur : 16'hDEAD;
        end
    end

    always @(negedge clk_cpu) begin
        for (int u = 0; u < NU; u++) begin
            if (!sram_oe[u] && sram_d_oe[u]) viol_oe <= viol_oe + 1;
            if (!sram_we[u] && sram_ce[u])   viol_we <= viol_we + 1;
            if (dm_ack[u])  ack_cnt[u] <= ack_cnt[u] + 1;
            if (!sram_we[u]) we_low[u] <= we_low[u] + 1;
            if (!sram_ub[u]) ub_low[u] <= ub_low[u] + 1;
        end
    end

    // Reference model: word memory per unit, plus the last value each unit returned.
    logic [15:0] ref_mem [int];
    logic [15:0] last_rd [NU] = '{default: 16'h0000};

    function automatic logic [15:0] model_read(input int u, input logic [15:0] adr);
        int key;
        key = u * 65536 + int'(adr);
        return ref_mem.exists(key) ? ref_mem[key] : init_val(adr);
    endfunction

    function automatic void model_write(input int u, input logic [15:0] adr,
                                        input logic [15:0] dat, input logic [1:0] sel);
        logic [15:0] w;
        w = model_read(u, adr);
        if (sel[0]) w[7:0]  = dat[7:0];
        if (sel[1]) w[15:8] = dat[15:8];
        ref_mem[u * 65536 + int'(adr)] = w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic txn(input string tag, input int u, input bit we, input logic [15:0] adr,
                       input logic [15:0] dat, input logic [1:0] sel,
                       input int exp_ack, input logic [15:0] exp_rd);
        int ack_cyc;
        int a0;
        int w0;
        logic [17:0] a_seen;
        logic [15:0] rdata;
        @(posedge clk_cpu); #1;
        dm_adr[u]   = adr;
        dm_dat_o[u] = dat;
        dm_we[u]    = we;
        dm_req[u]   = 1'b1;
`ifdef SRAM_BYTE_EN
        dm_sel[u]   = sel;
`endif
        a0 = ack_cnt[u];
        w0 = we_low[u];
        ack_cyc = -1;
        a_seen = '0;
        rdata = '0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk_cpu); #1;
            if (c == 1) begin
                a_seen      = sram_a[u];
                dm_adr[u]   = 16'($urandom);
                dm_dat_o[u] = 16'($urandom);
                dm_we[u]    = ~we;
`ifdef SRAM_BYTE_EN
                dm_sel[u]   = ~sel;
`endif
            end
            if (dm_ack[u]) begin
                ack_cyc = c;
                rdata = dm_dat_i[u];
                break;
            end
        end
        dm_req[u] = 1'b0;
        if (ack_cyc < 0) rdata = dm_dat_i[u];
        @(negedge clk_cpu); #1;
        $display("txn %s: unit=%0d we=%0b adr=%h dat=%h sel=%b ack_cycle=%0d rdata=%h",
                 tag, u, we, adr, dat, sel, ack_cyc, rdata);
        chk({tag, "_ack_cycle"}, 32'(ack_cyc), 32'(exp_ack));
        chk({tag, "_addr"},      32'(a_seen), {14'd0, 2'b00, adr});
        chk({tag, "_rdata"},     {16'd0, rdata}, {16'd0, exp_rd});
        chk({tag, "_we_low"},    32'(we_low[u] - w0), 32'(we ? ws_of(u) + 1 : 0));
        chk({tag, "_ack_count"}, 32'(ack_cnt[u] - a0), 32'd1);
    endtask

    typedef struct {
        int          u;
        bit          we;
        logic [15:0] adr;
        logic [15:0] dat;
        int          exp_ack;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          u;
        bit          we;
        logic [15:0] adr;
        logic [15:0] dat;
        logic [1:0]  sel;
        logic [15:0] exp;
        int          a0;

        vecs[0] = '{0, 1'b1, 16'h1234, 16'hBEEF, 5, 16'h0000};
        vecs[1] = '{0, 1'b0, 16'h1234, 16'h0000, 4, 16'hBEEF};
        vecs[2] = '{1, 1'b1, 16'h0040, 16'h1111, 4, 16'h0000};
        vecs[3] = '{1, 1'b0, 16'h0040, 16'h0000, 3, 16'h1111};
        vecs[4] = '{2, 1'b1, 16'h0041, 16'h2222, 7, 16'h0000};
        vecs[5] = '{2, 1'b0, 16'h0041, 16'h0000, 6, 16'h2222};
        vecs[6] = '{2, 1'b0, 16'h0099, 16'h0000, 6, 16'hA53C};
        vecs[7] = '{0, 1'b0, 16'h0041, 16'h0000, 4, 16'hA5E4};

        dm_req   = '0;
        dm_we    = '0;
        dm_adr   = '0;
        dm_dat_o = '0;
`ifdef SRAM_BYTE_EN
        dm_sel   = '1;
`endif
        repeat (3) @(posedge clk_cpu);
        #1;
        for (int i = 0; i < NU; i++) begin
            chk("reset_strobes", {25'd0, sram_ce[i], sram_we[i], sram_oe[i], sram_lb[i],
                                  sram_ub[i], sram_d_oe[i], dm_ack[i]}, 32'b1111100);
            chk("reset_addr",     {14'd0, sram_a[i]},   32'd0);
            chk("reset_dout",     {16'd0, sram_d_o[i]}, 32'd0);
            chk("reset_rdata",    {16'd0, dm_dat_i[i]}, 32'd0);
        end
        @(negedge clk_cpu);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            txn($sformatf("vec%0d", i), vecs[i].u, vecs[i].we, vecs[i].adr, vecs[i].dat,
                2'b11, vecs[i].exp_ack, vecs[i].exp_rd);
            if (vecs[i].we) model_write(vecs[i].u, vecs[i].adr, vecs[i].dat, 2'b11);
            else last_rd[vecs[i].u] = vecs[i].exp_rd;
        end

        for (int i = 0; i < 60; i++) begin
            u   = $urandom_range(0, NU - 1);
            we  = 1'($urandom_range(0, 1));
            adr = 16'h0100 + 16'($urandom_range(0, 7));
            dat = 16'($urandom);
`ifdef SRAM_BYTE_EN
            sel = 2'($urandom_range(0, 3));
`else
            sel = 2'b11;
`endif
            if (we) begin
                txn("rnd_wr", u, 1'b1, adr, dat, sel, ws_of(u) + 4, last_rd[u]);
                model_write(u, adr, dat, sel);
            end else begin
                exp = model_read(u, adr);
                txn("rnd_rd", u, 1'b0, adr, dat, sel, ws_of(u) + 3, exp);
                last_rd[u] = exp;
            end
        end

        // Read data must survive a following write.
        txn("hold_wr1", 1, 1'b1, 16'h0300, 16'hC0DE, 2'b11, 4, last_rd[1]);
        txn("hold_rd",  1, 1'b0, 16'h0300, 16'h0000, 2'b11, 3, 16'hC0DE);
        txn("hold_wr2", 1, 1'b1, 16'h0301, 16'h0000, 2'b11, 4, 16'hC0DE);
        repeat (3) @(posedge clk_cpu);
        #1;
        chk("hold_after_idle", {16'd0, dm_dat_i[1]}, {16'd0, 16'hC0DE});

        // Back-to-back write/read/write with request held until ack.
        txn("b2b_wr1", 2, 1'b1, 16'h0310, 16'h1357, 2'b11, 7, last_rd[2]);
        txn("b2b_rd",  2, 1'b0, 16'h0310, 16'h0000, 2'b11, 6, 16'h1357);
        txn("b2b_wr2", 2, 1'b1, 16'h0310, 16'h2468, 2'b11, 7, 16'h1357);
        txn("b2b_rd2", 2, 1'b0, 16'h0310, 16'h0000, 2'b11, 6, 16'h2468);

`ifdef SRAM_BYTE_EN
        txn("lane_fill", 0, 1'b1, 16'h0200, 16'hFFFF, 2'b11, 5, last_rd[0]);
        a0 = ub_low[0];
        txn("lane_lo",   0, 1'b1, 16'h0200, 16'hAA55, 2'b01, 5, last_rd[0]);
        chk("lane_ub_idle", 32'(ub_low[0] - a0), 32'd0);
        txn("lane_rd",   0, 1'b0, 16'h0200, 16'h0000, 2'b11, 4, 16'hFF55);
        txn("lane_rd00", 0, 1'b0, 16'h0200, 16'h0000, 2'b00, 4, 16'hFF55);
`endif

        // Reset asserted while a write sits in ACCESS on the WAIT_STATES=3 unit.
        @(posedge clk_cpu); #1;
        dm_adr[2]   = 16'h0077;
        dm_dat_o[2] = 16'h5555;
        dm_we[2]    = 1'b1;
        dm_req[2]   = 1'b1;
        repeat (3) @(posedge clk_cpu);
        #2;
        chk("pre_reset_we_low", {31'd0, sram_we[2]}, 32'd0);
        a0 = ack_cnt[2];
        rst = 1'b1;
        #1;
        chk("async_reset_strobes", {29'd0, sram_we[2], sram_ce[2], sram_d_oe[2]}, 32'b110);
        dm_req[2] = 1'b0;
        @(negedge clk_cpu);
        rst = 1'b0;
        repeat (8) @(posedge clk_cpu);
        #1;
        chk("reset_no_ack", 32'(ack_cnt[2] - a0), 32'd0);
        txn("post_reset_rd", 2, 1'b0, 16'h0500, 16'h0000, 2'b11, 6, init_val(16'h0500));

        chk("no_oe_doe_overlap", 32'(viol_oe), 32'd0);
        chk("no_we_without_ce",  32'(viol_we), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
